// File: rtl/pq_front_end.sv
// Front-end controller for a 31-entry min-heap event queue: arbitrates producers into a staging FIFO
// and serialises enqueues/dequeues to the heap. Optional counters built when PQ_STATS_EN is defined.
//
//  state | meaning
//  RUN   | may issue one heap op (dequeue preferred over enqueue)
//  HOLD  | settle bubble after a dequeue; no heap op, deq_req ignored
module pq_front_end #(
    parameter int DW   = 16,
    parameter int NP   = 4,
    parameter int FAW  = 3,
    parameter int QCAP = 31
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic [NP-1:0]     in_vld,
    input  logic [NP*DW-1:0]  in_data,
    output logic [NP-1:0]     in_rdy,
    input  logic              deq_req,
    output logic              deq_vld,
    output logic [DW-1:0]     deq_data,
    output logic              pq_enq,
    output logic              pq_deq,
    output logic [DW-1:0]     pq_inp_data,
    input  logic [DW-1:0]     pq_out_data,
    input  logic [4:0]        pq_count,
    output logic [FAW:0]      fifo_lvl,
    output logic [31:0]       stat_enq_cnt,
    output logic [31:0]       stat_deq_cnt
);

    localparam int PW    = (NP > 1) ? $clog2(NP) : 1;
    localparam int DEPTH = 1 << FAW;

    typedef enum logic {S_RUN, S_HOLD} state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   rr_nxt;
    logic [PW-1:0]   idx_p;
    logic [DW-1:0]   in_word [NP];
    logic [DW-1:0]   mem [DEPTH];
    logic [FAW-1:0]  wr_ptr;
    logic [FAW-1:0]  rd_ptr;
    logic [DW-1:0]   wr_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            do_deq;
    logic            do_enq;
    logic [5:0]      cnt_eff;

    for (genvar i = 0; i < NP; i++) begin : g_word
        assign in_word[i] = in_data[i*DW +: DW];
    end

    assign fifo_full  = (fifo_lvl == (FAW+1)'(DEPTH));
    assign fifo_empty = (fifo_lvl == '0);

    // Round-robin: first valid producer at or after rr_ptr, wrapping.
    always_comb begin
        in_rdy  = '0;
        push    = 1'b0;
        rr_nxt  = rr_ptr;
        wr_data = '0;
        idx_p   = '0;
        for (int k = 0; k < NP; k++) begin
            idx_p = PW'((int'(rr_ptr) + k) % NP);
            if (!fifo_full && !push && in_vld[idx_p]) begin
                in_rdy[idx_p] = 1'b1;
                push          = 1'b1;
                wr_data       = in_word[idx_p];
                rr_nxt        = PW'((int'(idx_p) + 1) % NP);
            end
        end
    end

    // The heap reflects an enqueue one edge late, so the strobe in flight counts as occupied.
    assign cnt_eff = {1'b0, pq_count} + {5'b0, pq_enq};
    assign do_deq  = (state == S_RUN) && deq_req && (pq_count != 5'd0);
    assign do_enq  = (state == S_RUN) && !do_deq && !fifo_empty && (32'(cnt_eff) < QCAP);
    assign pop     = do_enq;

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_lvl <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= rr_nxt;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_lvl <= fifo_lvl + 1'b1;
                2'b01:   fifo_lvl <= fifo_lvl - 1'b1;
                default: fifo_lvl <= fifo_lvl;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state       <= S_RUN;
            pq_enq      <= 1'b0;
            pq_deq      <= 1'b0;
            pq_inp_data <= '0;
            deq_vld     <= 1'b0;
            deq_data    <= '0;
        end else begin
            pq_enq  <= do_enq;
            pq_deq  <= do_deq;
            deq_vld <= (state == S_HOLD);
            if (do_enq) pq_inp_data <= mem[rd_ptr];
            // Root sampled in the issue cycle, before the heap reorganises.
            if (do_deq) deq_data <= pq_out_data;
            case (state)
                S_RUN:   if (do_deq) state <= S_HOLD;
                S_HOLD:  state <= S_RUN;
                default: state <= S_RUN;
            endcase
        end
    end

`ifdef PQ_STATS_EN
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            stat_enq_cnt <= '0;
            stat_deq_cnt <= '0;
        end else begin
            if (do_enq) stat_enq_cnt <= stat_enq_cnt + 32'd1;
            if (do_deq) stat_deq_cnt <= stat_deq_cnt + 32'd1;
        end
    end
`else
    assign stat_enq_cnt = '0;
    assign stat_deq_cnt = '0;
`endif

endmodule

// File: tb/tb_pq_front_end.sv
// Bench for pq_front_end: queue-based reference model plus a behavioural min-heap,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pq_front_end;

    localparam int DW   = 16;
    localparam int NP   = 4;
    localparam int QCAP = 31;

    logic          CLK = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    in_vld;
    logic [63:0]   in_data;
    logic [3:0]    in_rdy;
    logic          deq_req;
    logic          deq_vld;
    logic [15:0]   deq_data;
    logic          pq_enq;
    logic          pq_deq;
    logic [15:0]   pq_inp_data;
    logic [15:0]   pq_out_data;
    logic [4:0]    pq_count;
    logic [3:0]    fifo_lvl;
    logic [31:0]   stat_enq_cnt;
    logic [31:0]   stat_deq_cnt;

    always #5 CLK = ~CLK;

    pq_front_end dut (
        .CLK(CLK), .rst(rst),
        .in_vld(in_vld), .in_data(in_data), .in_rdy(in_rdy),
        .deq_req(deq_req), .deq_vld(deq_vld), .deq_data(deq_data),
        .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_inp_data(pq_inp_data),
        .pq_out_data(pq_out_data), .pq_count(pq_count),
        .fifo_lvl(fifo_lvl), .stat_enq_cnt(stat_enq_cnt), .stat_deq_cnt(stat_deq_cnt)
    );

    int n_chk = 0;
    int n_err = 0;

    // reference model: staging queue, pointer, settle flag, expected registered outputs
    logic [15:0]  mq[$];
    int           rr;
    bit           m_hold;
    bit           e_enq, e_deq, e_dvld;
    logic [15:0]  e_inp, e_ddata;
    int unsigned  e_senq, e_sdeq;

    // behavioural heap
    logic [15:0]  hq[$];
    bit           l_enq, l_deq;
    logic [15:0]  l_data;

    logic [3:0]   last_rdy;
    int           n_enq_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int grant_of(input logic [3:0] v);
        if (mq.size() >= 8) return -1;
        for (int k = 0; k < NP; k++) begin
            int idx = (rr + k) % NP;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic heap_refresh();
        logic [15:0] m;
        m = 16'hFFFF;
        foreach (hq[i]) if (hq[i] < m) m = hq[i];
        pq_count    = 5'(hq.size());
        pq_out_data = (hq.size() > 0) ? m : 16'h0;
    endtask

    task automatic heap_apply();
        chk("strobe_excl", 32'(l_enq & l_deq), 32'd0);
        if (l_enq) begin
            chk("enq_room", 32'(hq.size() < QCAP), 32'd1);
            if (hq.size() < QCAP) hq.push_back(l_data);
        end else if (l_deq) begin
            chk("deq_nonempty", 32'(hq.size() > 0), 32'd1);
            if (hq.size() > 0) begin
                int mi = 0;
                foreach (hq[i]) if (hq[i] < hq[mi]) mi = i;
                hq.delete(mi);
            end
        end
        heap_refresh();
    endtask

    task automatic heap_set(input int n, input logic [15:0] base);
        hq.delete();
        for (int i = 0; i < n; i++) hq.push_back(base + 16'(i));
        heap_refresh();
    endtask

    task automatic check_all();
        int g = grant_of(in_vld);
        chk("in_rdy", 32'(in_rdy), (g >= 0) ? 32'(1 << g) : 32'd0);
        chk("pq_enq", 32'(pq_enq), 32'(e_enq));
        chk("pq_deq", 32'(pq_deq), 32'(e_deq));
        if (e_enq) chk("pq_inp_data", 32'(pq_inp_data), 32'(e_inp));
        chk("deq_vld", 32'(deq_vld), 32'(e_dvld));
        if (e_dvld) chk("deq_data", 32'(deq_data), 32'(e_ddata));
        chk("fifo_lvl", 32'(fifo_lvl), 32'(mq.size()));
`ifdef PQ_STATS_EN
        chk("stat_enq_cnt", stat_enq_cnt, e_senq);
        chk("stat_deq_cnt", stat_deq_cnt, e_sdeq);
`else
        chk("stat_enq_cnt", stat_enq_cnt, 32'd0);
        chk("stat_deq_cnt", stat_deq_cnt, 32'd0);
`endif
    endtask

    // what the next clock edge must produce, from the current inputs
    task automatic model_advance();
        int g = grant_of(in_vld);
        bit n_enq = 1'b0;
        bit n_deq = 1'b0;
        bit n_dvld = 1'b0;
        if (m_hold) begin
            n_dvld = 1'b1;
            m_hold = 1'b0;
        end else if (deq_req && pq_count > 0) begin
            n_deq   = 1'b1;
            e_ddata = pq_out_data;
            m_hold  = 1'b1;
            e_sdeq++;
        end else if (mq.size() > 0 && int'(pq_count) + int'(e_enq) < QCAP) begin
            n_enq = 1'b1;
            e_inp = mq.pop_front();
            e_senq++;
        end
        if (g >= 0) begin
            mq.push_back(16'(in_data >> (g * DW)));
            rr = (g + 1) % NP;
        end
        e_enq  = n_enq;
        e_deq  = n_deq;
        e_dvld = n_dvld;
    endtask

    task automatic tick();
        #1;
        last_rdy = in_rdy;
        check_all();
        if (pq_enq) n_enq_seen++;
        l_enq  = pq_enq;
        l_deq  = pq_deq;
        l_data = pq_inp_data;
        model_advance();
        @(negedge CLK);
        heap_apply();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        in_vld  = '0;
        in_data = '0;
        deq_req = 1'b0;
        hq.delete();
        heap_refresh();
        l_enq = 1'b0;
        l_deq = 1'b0;
        repeat (2) @(negedge CLK);
        mq.delete();
        rr = 0; m_hold = 0;
        e_enq = 0; e_deq = 0; e_dvld = 0; e_inp = '0; e_ddata = '0;
        e_senq = 0; e_sdeq = 0;
        rst = 1'b0;
    endtask

    logic [3:0] gq[$];
    logic [15:0] h5[$];

    initial begin
        in_vld = '0; in_data = '0; deq_req = 1'b0;
        do_reset();
        chk("rst_fifo_lvl", 32'(fifo_lvl), 32'd0);
        chk("rst_pq_enq", 32'(pq_enq), 32'd0);
        chk("rst_pq_deq", 32'(pq_deq), 32'd0);
        chk("rst_deq_vld", 32'(deq_vld), 32'd0);
        chk("rst_deq_data", 32'(deq_data), 32'd0);
        chk("rst_stat_enq", stat_enq_cnt, 32'd0);
        repeat (10) tick();

        // producer 2 alone, heap empty
        in_vld = 4'b0100;
        in_data = '0;
        in_data[2*DW +: DW] = 16'h0040;
        #1 chk("p2_in_rdy", 32'(in_rdy), 32'h4);
        tick();
        in_vld = '0;
        tick();
        chk("p2_enq_2cyc", 32'(pq_enq), 32'd1);
        chk("p2_inp_data", 32'(pq_inp_data), 32'h0040);
        repeat (3) tick();

        // fill FIFO with heap full, then hold deq_req and watch grants rotate
        heap_set(31, 16'h2000);
        in_vld = 4'b0001;
        in_data = {$urandom, $urandom};
        tick();
        in_vld = 4'b1111;
        for (int i = 0; i < 7; i++) begin
            in_data = {$urandom, $urandom};
            tick();
        end
        chk("full_lvl", 32'(fifo_lvl), 32'd8);
        #1 chk("full_in_rdy", 32'(in_rdy), 32'd0);
        deq_req = 1'b1;
        for (int i = 0; i < 200; i++) begin
            in_data = {$urandom, $urandom};
            tick();
            if (last_rdy != 4'b0) gq.push_back(last_rdy);
        end
        chk("rot_count", 32'(gq.size() >= 5), 32'd1);
        if (gq.size() >= 5) begin
            chk("rot_0", 32'(gq[0]), 32'h1);
            chk("rot_1", 32'(gq[1]), 32'h2);
            chk("rot_2", 32'(gq[2]), 32'h4);
            chk("rot_3", 32'(gq[3]), 32'h8);
            chk("rot_4", 32'(gq[4]), 32'h1);
        end
        in_vld = '0;
        deq_req = 1'b0;
        tick();

        // heap at capacity, three staged events: a single dequeue frees exactly one slot
        do_reset();
        heap_set(31, 16'h1000);
        for (int i = 0; i < 3; i++) begin
            in_vld = 4'(1 << i);
            in_data = '0;
            in_data[i*DW +: DW] = 16'(16'h0500 + i);
            tick();
        end
        in_vld = '0;
        n_enq_seen = 0;
        repeat (5) tick();
        chk("cap_no_enq", 32'(n_enq_seen), 32'd0);
        chk("cap_lvl3", 32'(fifo_lvl), 32'd3);
        deq_req = 1'b1;
        tick();
        deq_req = 1'b0;
        repeat (8) tick();
        chk("cap_one_enq", 32'(n_enq_seen), 32'd1);
        chk("cap_lvl2", 32'(fifo_lvl), 32'd2);
        chk("cap_heap31", 32'(pq_count), 32'd31);

        // dequeue beats a pending enqueue; settle bubble follows
        do_reset();
        h5 = '{16'h0030, 16'h0007, 16'h0100, 16'h0050, 16'h0009};
        hq.delete();
        foreach (h5[i]) hq.push_back(h5[i]);
        heap_refresh();
        in_vld = 4'b0010;
        in_data = '0;
        in_data[1*DW +: DW] = 16'h0003;
        tick();
        in_vld = '0;
        deq_req = 1'b1;
        tick();
        chk("pri_deq", 32'(pq_deq), 32'd1);
        chk("pri_no_enq", 32'(pq_enq), 32'd0);
        tick();
        chk("pri_deq_vld", 32'(deq_vld), 32'd1);
        chk("pri_deq_data", 32'(deq_data), 32'h0007);
        chk("hold_no_enq", 32'(pq_enq), 32'd0);
        chk("hold_no_deq", 32'(pq_deq), 32'd0);
        deq_req = 1'b0;
        repeat (4) tick();

        // dequeue request against an empty heap waits for the enqueue to land
        do_reset();
        deq_req = 1'b1;
        in_vld = 4'b1000;
        in_data = '0;
        in_data[3*DW +: DW] = 16'h0123;
        tick();
        chk("empty_no_deq0", 32'(pq_deq), 32'd0);
        in_vld = '0;
        tick();
        chk("empty_enq", 32'(pq_enq), 32'd1);
        chk("empty_no_deq1", 32'(pq_deq), 32'd0);
        tick();
        chk("empty_no_deq2", 32'(pq_deq), 32'd0);
        tick();
        chk("empty_deq_fires", 32'(pq_deq), 32'd1);
        tick();
        chk("empty_deq_vld", 32'(deq_vld), 32'd1);
        chk("empty_deq_data", 32'(deq_data), 32'h0123);
        deq_req = 1'b0;
        tick();
`ifdef PQ_STATS_EN
        chk("stats_enq1", stat_enq_cnt, 32'd1);
        chk("stats_deq1", stat_deq_cnt, 32'd1);
`else
        chk("stats_off_enq", stat_enq_cnt, 32'd0);
        chk("stats_off_deq", stat_deq_cnt, 32'd0);
`endif

        // randomized traffic alternating fill-heavy and drain-heavy phases
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int ph = (i / 400) % 2;
            in_vld  = 4'($urandom_range(0, 15));
            in_data = {$urandom, $urandom};
            deq_req = (ph == 1) ? ($urandom_range(0, 99) < 60) : ($urandom_range(0, 99) < 8);
            tick();
        end
        in_vld = '0;
        deq_req = 1'b0;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
